// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: slice op codes,
// controller state encoding and the slice width.
package alu_nibble_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SLT_FIX = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit ALU ops one nibble per clock through an external 4-bit slice.
// Optional macro ALU_SEQ_LOGIC_BYPASS_EN: AND/OR are computed at accept, skipping the slice.
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic [3:0]       slice_result,
    input  logic             slice_cout,
    input  logic             slice_set,
    input  logic             slice_overflow
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int NIB_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(N - 1);

    typedef logic [N-1:0][NIBBLE_W-1:0] nib_vec_t;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    nib_vec_t         a_q, a_d, b_q, b_d, res_q, res_d;
    logic [NIB_W-1:0] nib_q, nib_d;
    logic             carry_q, carry_d;
    logic             set_q, set_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        nib_d      = nib_q;
        carry_d    = carry_q;
        set_d      = set_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        slice_a    = '0;
        slice_b    = '0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        slice_op   = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    nib_d   = '0;
                    carry_d = in_op[2];
                    state_d = ST_RUN;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
                    if (in_op == OP_AND || in_op == OP_OR) begin
                        res_d   = (in_op == OP_AND) ? (in_a & in_b) : (in_a | in_b);
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        zero_d  = ~|res_d;
                        state_d = ST_DONE;
                    end
`endif
                end
            end

            ST_RUN: begin
                slice_a       = a_q[nib_q];
                slice_b       = b_q[nib_q];
                slice_cin     = carry_q;
                slice_op      = op_q;
                res_d[nib_q]  = slice_result;
                carry_d       = slice_cout;
                nib_d         = nib_q + 1'b1;
                if (nib_q == LAST_NIB) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_overflow;
                    set_d   = slice_set;
                    zero_d  = ~|res_d;
                    state_d = (op_q == OP_SLT) ? ST_SLT_FIX : ST_DONE;
                end
            end

            // Second pass over nibble 0 feeds the MSB set flag back into the LSB less input.
            ST_SLT_FIX: begin
                slice_a    = a_q[0];
                slice_b    = b_q[0];
                slice_cin  = 1'b1;
                slice_less = set_q;
                slice_op   = op_q;
                res_d      = '0;
                res_d[0]   = slice_result;
                zero_d     = ~|res_d;
                state_d    = ST_DONE;
            end

            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nib_q   <= '0;
            carry_q <= 1'b0;
            set_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nib_q   <= nib_d;
            carry_q <= carry_d;
            set_q   <= set_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign out_result   = res_q;
    assign out_cout     = cout_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (WIDTH=16) driving a behavioural 4-bit ALU slice
// and checking results against a whole-word arithmetic reference model.
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout, out_overflow, out_zero;
    logic [3:0]       slice_a, slice_b, slice_result;
    logic             slice_cin, slice_less, slice_cout, slice_set, slice_overflow;
    logic [2:0]       slice_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cout(out_cout), .out_overflow(out_overflow), .out_zero(out_zero),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_less(slice_less),
        .slice_op(slice_op), .slice_result(slice_result), .slice_cout(slice_cout),
        .slice_set(slice_set), .slice_overflow(slice_overflow)
    );

    // Behavioural 4-bit slice: op[2] inverts b, op[1:0] selects AND/OR/SUM/LESS.
    logic [3:0] bb;
    logic [4:0] s5;
    logic [3:0] s3;
    always_comb begin
        bb             = slice_op[2] ? ~slice_b : slice_b;
        s5             = {1'b0, slice_a} + {1'b0, bb} + {4'b0, slice_cin};
        s3             = {1'b0, slice_a[2:0]} + {1'b0, bb[2:0]} + {3'b0, slice_cin};
        slice_cout     = s5[4];
        slice_set      = s5[3];
        slice_overflow = s3[3] ^ s5[4];
        case (slice_op[1:0])
            2'b00:   slice_result = slice_a & bb;
            2'b01:   slice_result = slice_a | bb;
            2'b10:   slice_result = s5[3:0];
            default: slice_result = {3'b000, slice_less};
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
        logic             zero;
        int               lat;
    } exp_t;

    function automatic exp_t ref_model(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] add_full, sub_full;
        logic add_ovf, sub_ovf;
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} + {1'b0, ~b} + 1;
        add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
        sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
        e.lat    = N + 1;
        case (op)
            3'b000:  begin e.res = a & b; e.cout = add_full[WIDTH]; e.ovf = add_ovf; end
            3'b001:  begin e.res = a | b; e.cout = add_full[WIDTH]; e.ovf = add_ovf; end
            3'b110:  begin e.res = sub_full[WIDTH-1:0]; e.cout = sub_full[WIDTH]; e.ovf = sub_ovf; end
            3'b111:  begin
                e.res  = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1]};
                e.cout = sub_full[WIDTH];
                e.ovf  = sub_ovf;
                e.lat  = N + 2;
            end
            default: begin e.res = add_full[WIDTH-1:0]; e.cout = add_full[WIDTH]; e.ovf = add_ovf; end
        endcase
        if (BYPASS && (op == 3'b000 || op == 3'b001)) begin
            e.cout = 1'b0;
            e.ovf  = 1'b0;
            e.lat  = 1;
        end
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Issues one op and returns edges from the accept edge (inclusive) to out_valid.
    task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_op    = 3'($urandom);
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        #1;
        checks += 10;
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_result !== '0)  begin errors++; $display("FAIL reset_result: got %h want 0", out_result); end
        if (out_cout !== 1'b0)  begin errors++; $display("FAIL reset_cout: got %b want 0", out_cout); end
        if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_overflow); end
        if (out_zero !== 1'b0)  begin errors++; $display("FAIL reset_zero: got %b want 0", out_zero); end
        if (slice_a !== 4'h0 || slice_b !== 4'h0) begin errors++; $display("FAIL reset_slice_ab: got %h/%h want 0/0", slice_a, slice_b); end
        if (slice_cin !== 1'b0) begin errors++; $display("FAIL reset_slice_cin: got %b want 0", slice_cin); end
        if (slice_less !== 1'b0) begin errors++; $display("FAIL reset_slice_less: got %b want 0", slice_less); end
        if (slice_op !== 3'b000) begin errors++; $display("FAIL reset_slice_op: got %b want 000", slice_op); end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic [WIDTH-1:0] a, b, res;
        logic             cout, ovf, zero;
        int               lat;
    } dir_t;

    task automatic test_directed();
        dir_t v[5];
        int lat;
        v[0] = '{"add_ovf",  3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, N + 1};
        v[1] = '{"sub_zero", 3'b110, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, N + 1};
        v[2] = '{"slt_true", 3'b111, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, N + 2};
        v[3] = '{"slt_false",3'b111, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, N + 2};
        v[4] = '{"and",      3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, !BYPASS, 1'b0, 1'b0, BYPASS ? 1 : N + 1};
        foreach (v[i]) begin
            do_op(v[i].op, v[i].a, v[i].b, lat);
            checks += 5;
            if (out_result !== v[i].res) begin errors++; $display("FAIL %s_result: got %h want %h", v[i].name, out_result, v[i].res); end
            if (out_cout !== v[i].cout) begin errors++; $display("FAIL %s_cout: got %b want %b", v[i].name, out_cout, v[i].cout); end
            if (out_overflow !== v[i].ovf) begin errors++; $display("FAIL %s_ovf: got %b want %b", v[i].name, out_overflow, v[i].ovf); end
            if (out_zero !== v[i].zero) begin errors++; $display("FAIL %s_zero: got %b want %b", v[i].name, out_zero, v[i].zero); end
            if (lat != v[i].lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
            release_result();
        end
    endtask

    bit   rec_en = 1'b0;
    logic cin_log[$];
    always @(negedge clk) begin
        if (rec_en && slice_op == 3'b110) cin_log.push_back(slice_cin);
    end

    // Carry into each nibble of a SUB is the carry out of the low bits of a + ~b + 1.
    task automatic test_sub_carry_chain();
        logic [WIDTH-1:0] av[2] = '{16'h1234, 16'h0100};
        logic [WIDTH-1:0] bv[2] = '{16'h1234, 16'h0001};
        int lat;
        for (int t = 0; t < 2; t++) begin
            cin_log.delete();
            rec_en = 1'b1;
            do_op(3'b110, av[t], bv[t], lat);
            rec_en = 1'b0;
            checks++;
            if (cin_log.size() != N) begin
                errors++; $display("FAIL sub_cin_count[%0d]: got %0d want %0d", t, cin_log.size(), N);
            end else begin
                for (int k = 0; k < N; k++) begin
                    logic [31:0] m, s;
                    logic exp_cin;
                    m = (32'd1 << (4 * k)) - 1;
                    s = (32'(av[t]) & m) + (32'(~bv[t]) & m) + 1;
                    exp_cin = (k == 0) ? 1'b1 : s[4 * k];
                    checks++;
                    if (cin_log[k] !== exp_cin) begin
                        errors++; $display("FAIL sub_cin[%0d] nib%0d: got %b want %b", t, k, cin_log[k], exp_cin);
                    end
                end
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        int lat;
        exp_t e;
        e = ref_model(3'b010, 16'h4321, 16'h1111);
        do_op(3'b010, 16'h4321, 16'h1111, lat);
        in_op = 3'b110; in_a = 16'hAAAA; in_b = 16'h0001; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks += 5;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid c%0d: got %b want 1", c, out_valid); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready c%0d: got %b want 0", c, in_ready); end
            if (out_result !== e.res) begin errors++; $display("FAIL hold_result c%0d: got %h want %h", c, out_result, e.res); end
            if (out_cout !== e.cout || out_overflow !== e.ovf) begin
                errors++; $display("FAIL hold_flags c%0d: got %b%b want %b%b", c, out_cout, out_overflow, e.cout, e.ovf);
            end
            if (out_zero !== e.zero) begin errors++; $display("FAIL hold_zero c%0d: got %b want %b", c, out_zero, e.zero); end
        end
        in_valid = 1'b0;
        release_result();
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        in_op = 3'b010; in_a = 16'h1111; in_b = 16'h2222; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks += 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        if (slice_op !== 3'b000) begin errors++; $display("FAIL rstmid_slice_op: got %b want 000", slice_op); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (N + 2) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_result: got %b want 0", out_valid); end
        do_op(3'b010, 16'h0001, 16'h0001, lat);
        checks += 2;
        if (out_result !== 16'h0002) begin errors++; $display("FAIL rstmid_next_add: got %h want 0002", out_result); end
        if (lat != N + 1) begin errors++; $display("FAIL rstmid_next_latency: got %0d want %0d", lat, N + 1); end
        release_result();
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        in_op = 3'b010; in_a = 16'h0F0F; in_b = 16'h0101; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3 * (N + 2); c++) begin
            if (in_ready) accepts.push_back(c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (N + 3) begin @(posedge clk); #1; end
        checks++;
        if (accepts.size() < 2) begin
            errors++; $display("FAIL b2b_accepts: got %0d want >=2", accepts.size());
        end else begin
            for (int i = 1; i < accepts.size(); i++) begin
                checks++;
                if (accepts[i] - accepts[i-1] != N + 2) begin
                    errors++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", i, accepts[i] - accepts[i-1], N + 2);
                end
            end
        end
        if (out_valid) release_result();
    endtask

    task automatic test_random();
        logic [2:0] ops[5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        logic [WIDTH-1:0] edge_vals[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [WIDTH-1:0] a, b;
            exp_t e;
            int lat;
            op = ops[$urandom_range(4)];
            a  = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : WIDTH'($urandom);
            b  = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(3)] : WIDTH'($urandom);
            e  = ref_model(op, a, b);
            do_op(op, a, b, lat);
            checks += 5;
            if (out_result !== e.res) begin errors++; $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h want %h", i, op, a, b, out_result, e.res); end
            if (out_cout !== e.cout) begin errors++; $display("FAIL rnd%0d_cout op=%b a=%h b=%h: got %b want %b", i, op, a, b, out_cout, e.cout); end
            if (out_overflow !== e.ovf) begin errors++; $display("FAIL rnd%0d_ovf op=%b a=%h b=%h: got %b want %b", i, op, a, b, out_overflow, e.ovf); end
            if (out_zero !== e.zero) begin errors++; $display("FAIL rnd%0d_zero op=%b: got %b want %b", i, op, out_zero, e.zero); end
            if (lat != e.lat) begin errors++; $display("FAIL rnd%0d_latency op=%b: got %0d want %0d", i, op, lat, e.lat); end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sub_carry_chain();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
